// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge sequencer.
// Takes 64-bit message lanes from the host and forwards them as indexed lanes to the absorb
// datapath. Appends the SHA3/SHAKE padding lanes and pulses a permutation start once per rate
// block. Then walks the digest lanes out to the host, re-permuting when the XOF output runs past
// one rate block.
// Ports:
//   clk_i, rst_ni                    clock; asynchronous active-low reset
//   mode_i, start_i, busy_o          hash mode (sampled on start), start request, busy flag
//   msg_in_i/msg_valid_i/msg_last_i  host message lane stream; msg_ready_o high only in ABSORB
//   lane_data_o/lane_idx_o           lane to XOR into the state, with its position in the rate block
//   lane_valid_o                     one-cycle strobe per lane
//   perm_start_o/perm_done_i         f_permutation start pulse and completion pulse
//   sq_idx_o/dig_valid_o             digest lane index the datapath presents, and its valid flag
//   dig_ready_i/dig_last_o           host accepts a digest lane; last-digest-lane flag
module keccak_sponge_ctrl #(
  parameter int unsigned XOF_LANES = 8,
  parameter logic [7:0]  SHA3_DS   = 8'h06,
  parameter logic [7:0]  SHAKE_DS  = 8'h1F
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  mode_i,
  input  logic        start_i,
  output logic        busy_o,
  input  logic [63:0] msg_in_i,
  input  logic        msg_valid_i,
  input  logic        msg_last_i,
  output logic        msg_ready_o,
  output logic [63:0] lane_data_o,
  output logic [4:0]  lane_idx_o,
  output logic        lane_valid_o,
  output logic        perm_start_o,
  input  logic        perm_done_i,
  output logic [4:0]  sq_idx_o,
  output logic        dig_valid_o,
  input  logic        dig_ready_i,
  output logic        dig_last_o
);

  typedef enum logic [2:0] {StIdle, StAbsorb, StPad, StPerm, StSqueeze, StSqPerm} state_e;

  localparam logic [5:0] XofD = 6'(XOF_LANES);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [4:0]  lane_cnt_q, lane_cnt_d;
  logic        pad_pend_q, pad_pend_d;    // last message lane filled a block; pad after the perm
  logic        pad_first_q, pad_first_d;  // next pad lane carries the domain byte
  logic        final_q, final_d;          // running perm is the last absorb perm
  logic [4:0]  sq_idx_q, sq_idx_d;
  logic [5:0]  dig_cnt_q, dig_cnt_d;
  logic [63:0] lane_data_q, lane_data_d;
  logic [4:0]  lane_idx_q, lane_idx_d;
  logic        lane_valid_q, lane_valid_d;
  logic        perm_start_q, perm_start_d;

  logic [4:0]  rate, rate_m1;
  logic [5:0]  dig_num;
  logic [7:0]  ds;
  logic [63:0] pad_lane;
  logic        lane_at_end;

  // Rate and digest length follow the mode latched at start.
  always_comb begin
    rate    = 5'd9;
    dig_num = 6'd8;
    unique case (mode_q)
      2'd0: begin rate = 5'd9;  dig_num = 6'd8; end
      2'd1: begin rate = 5'd17; dig_num = 6'd4; end
      2'd2: begin rate = 5'd21; dig_num = XofD; end
      2'd3: begin rate = 5'd17; dig_num = XofD; end
      default: ;
    endcase
  end

  assign rate_m1     = rate - 5'd1;
  assign lane_at_end = (lane_cnt_q == rate_m1);
  assign ds          = mode_q[1] ? SHAKE_DS : SHA3_DS;
  // Domain byte on the first pad lane, top bit on lane R-1; both land in one lane when they coincide.
  assign pad_lane    = ({lane_at_end, 63'b0}) | (pad_first_q ? {56'b0, ds} : 64'b0);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lane_cnt_d   = lane_cnt_q;
    pad_pend_d   = pad_pend_q;
    pad_first_d  = pad_first_q;
    final_d      = final_q;
    sq_idx_d     = sq_idx_q;
    dig_cnt_d    = dig_cnt_q;
    lane_data_d  = lane_data_q;
    lane_idx_d   = lane_idx_q;
    lane_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d     = mode_i;
          lane_cnt_d = 5'd0;
          pad_pend_d = 1'b0;
          final_d    = 1'b0;
          sq_idx_d   = 5'd0;
          dig_cnt_d  = 6'd0;
          state_d    = StAbsorb;
        end
      end
      StAbsorb: begin
        if (msg_valid_i) begin
          lane_data_d  = msg_in_i;
          lane_idx_d   = lane_cnt_q;
          lane_valid_d = 1'b1;
          if (msg_last_i) begin
            pad_first_d = 1'b1;
            if (lane_at_end) begin
              lane_cnt_d = 5'd0;
              pad_pend_d = 1'b1;
              state_d    = StPerm;
            end else begin
              lane_cnt_d = lane_cnt_q + 5'd1;
              state_d    = StPad;
            end
          end else if (lane_at_end) begin
            lane_cnt_d = 5'd0;
            state_d    = StPerm;
          end else begin
            lane_cnt_d = lane_cnt_q + 5'd1;
          end
        end
      end
      StPad: begin
        lane_data_d  = pad_lane;
        lane_idx_d   = lane_cnt_q;
        lane_valid_d = 1'b1;
        pad_first_d  = 1'b0;
        if (lane_at_end) begin
          lane_cnt_d = 5'd0;
          final_d    = 1'b1;
          state_d    = StPerm;
        end else begin
          lane_cnt_d = lane_cnt_q + 5'd1;
        end
      end
      StPerm: begin
        if (perm_done_i) begin
          if (pad_pend_q) begin
            pad_pend_d = 1'b0;
            state_d    = StPad;
          end else if (final_q) begin
            sq_idx_d  = 5'd0;
            dig_cnt_d = 6'd0;
            state_d   = StSqueeze;
          end else begin
            state_d = StAbsorb;
          end
        end
      end
      StSqueeze: begin
        if (dig_ready_i) begin
          if (dig_last_o) begin
            sq_idx_d  = 5'd0;
            dig_cnt_d = 6'd0;
            final_d   = 1'b0;
            state_d   = StIdle;
          end else begin
            dig_cnt_d = dig_cnt_q + 6'd1;
            if (sq_idx_q == rate_m1) begin
              state_d = StSqPerm;
            end else begin
              sq_idx_d = sq_idx_q + 5'd1;
            end
          end
        end
      end
      StSqPerm: begin
        if (perm_done_i) begin
          sq_idx_d = 5'd0;
          state_d  = StSqueeze;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so the pulse lands exactly on the first cycle of a permutation state.
    perm_start_d = ((state_d == StPerm) || (state_d == StSqPerm)) && (state_d != state_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mode_q       <= 2'd0;
      lane_cnt_q   <= 5'd0;
      pad_pend_q   <= 1'b0;
      pad_first_q  <= 1'b0;
      final_q      <= 1'b0;
      sq_idx_q     <= 5'd0;
      dig_cnt_q    <= 6'd0;
      lane_data_q  <= 64'd0;
      lane_idx_q   <= 5'd0;
      lane_valid_q <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      lane_cnt_q   <= lane_cnt_d;
      pad_pend_q   <= pad_pend_d;
      pad_first_q  <= pad_first_d;
      final_q      <= final_d;
      sq_idx_q     <= sq_idx_d;
      dig_cnt_q    <= dig_cnt_d;
      lane_data_q  <= lane_data_d;
      lane_idx_q   <= lane_idx_d;
      lane_valid_q <= lane_valid_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign msg_ready_o  = (state_q == StAbsorb);
  assign lane_data_o  = lane_data_q;
  assign lane_idx_o   = lane_idx_q;
  assign lane_valid_o = lane_valid_q;
  assign perm_start_o = perm_start_q;
  assign sq_idx_o     = sq_idx_q;
  assign dig_valid_o  = (state_q == StSqueeze);
  assign dig_last_o   = dig_valid_o && (dig_cnt_q == dig_num - 6'd1);

endmodule
